// File: rtl/seg_scan_ctrl_pkg.sv
// seg_pkg: shared segment patterns, scan FSM states and digit-select codes for the display scanner
package seg_pkg;
  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;
  localparam logic [7:0] SEG_0    = 8'hC0;
  localparam logic [7:0] SEG_1    = 8'hF9;
  localparam logic [7:0] SEG_2    = 8'hA4;
  localparam logic [7:0] SEG_3    = 8'hB0;
  localparam logic [7:0] SEG_4    = 8'h99;
  localparam logic [7:0] SEG_5    = 8'h92;
  localparam logic [7:0] SEG_6    = 8'h82;
  localparam logic [7:0] SEG_7    = 8'hF8;
  localparam logic [7:0] SEG_8    = 8'h80;
  localparam logic [7:0] SEG_9    = 8'h90;
  localparam logic [7:0] SEG_DASH = 8'hBF;
  localparam logic [7:0] SEG_OFF  = 8'hFF;
  localparam logic [2:0] WEI_U    = 3'b001;
  localparam logic [2:0] WEI_T    = 3'b010;
  localparam logic [2:0] WEI_H    = 3'b100;
endpackage

// File: rtl/seg_scan_ctrl_decode.sv
// seg7_decode: BCD nibble to active-low g..a segments; non-BCD shows a dash, blank forces all off
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = SEG_OFF[6:0];
    if (!blank_i)
      case (bcd_i)
        4'd0:    seg_o = SEG_0[6:0];
        4'd1:    seg_o = SEG_1[6:0];
        4'd2:    seg_o = SEG_2[6:0];
        4'd3:    seg_o = SEG_3[6:0];
        4'd4:    seg_o = SEG_4[6:0];
        4'd5:    seg_o = SEG_5[6:0];
        4'd6:    seg_o = SEG_6[6:0];
        4'd7:    seg_o = SEG_7[6:0];
        4'd8:    seg_o = SEG_8[6:0];
        4'd9:    seg_o = SEG_9[6:0];
        default: seg_o = SEG_DASH[6:0];
      endcase
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 3-digit multiplexed 7-segment scanner with per-slot blanking guard
// and frame-boundary req/ack loading of the displayed BCD frame
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIG   = 3,
  parameter int SLOT_CYC  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        res,
  input  logic [11:0] bcd_in,
  input  logic [2:0]  dp_in,
  input  logic        load_req,
  input  logic        lz_en,
  output logic        load_ack,
  output logic        frame_done,
  output logic [7:0]  seg,
  output logic [2:0]  wei
);
  localparam int CW = $clog2(SLOT_CYC);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  state_t        state_q, state_d;
  logic [11:0]   bcd_q;
  logic [2:0]    dp_q;
  logic [7:0]    seg_q, seg_d;
  logic [2:0]    wei_q, wei_d;
  logic          ack_q, done_q;
  logic          slot_end, frame_end, blank, dp_bit;
  logic [3:0]    dig;
  logic [6:0]    seg7;
  seg7_decode u_dec (.bcd_i(dig), .blank_i(blank), .seg_o(seg7));
  // state tracks the updated count so the registered outputs trail it by one cycle
  always_comb begin
    slot_end  = cnt_q == CW'(SLOT_CYC - 1);
    frame_end = slot_end && idx_q == 2'(NUM_DIG - 1);
    cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
    idx_d     = frame_end ? 2'd0 : slot_end ? idx_q + 2'd1 : idx_q;
    state_d   = cnt_d < CW'(BLANK_CYC) ? ST_BLANK : ST_DRIVE;
    dig       = idx_q == 2'd0 ? bcd_q[3:0] : idx_q == 2'd1 ? bcd_q[7:4] : bcd_q[11:8];
    dp_bit    = idx_q == 2'd0 ? dp_q[0] : idx_q == 2'd1 ? dp_q[1] : dp_q[2];
    blank     = lz_en && ((idx_q == 2'd2 && bcd_q[11:8] == 4'd0) ||
                          (idx_q == 2'd1 && bcd_q[11:4] == 8'd0));
    seg_d     = state_q == ST_DRIVE ? {~dp_bit, seg7} : SEG_OFF;
    wei_d     = state_q == ST_BLANK ? 3'b000 :
                idx_q == 2'd0 ? WEI_U : idx_q == 2'd1 ? WEI_T : WEI_H;
  end
  always_ff @(posedge clk) begin
    if (res) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      state_q <= ST_BLANK;
      bcd_q   <= '0;
      dp_q    <= '0;
      seg_q   <= SEG_OFF;
      wei_q   <= '0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      state_q <= state_d;
      bcd_q   <= frame_end && load_req ? bcd_in : bcd_q;
      dp_q    <= frame_end && load_req ? dp_in : dp_q;
      seg_q   <= seg_d;
      wei_q   <= wei_d;
      ack_q   <= frame_end && load_req;
      done_q  <= frame_end;
    end
  end
  assign seg        = seg_q;
  assign wei        = wei_q;
  assign load_ack   = ack_q;
  assign frame_done = done_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: table-driven frames through a scoreboard queue, checked against an
// independent scan-position model, plus reset and held-request sequences
module tb_seg_scan_ctrl;
  typedef struct packed {
    logic [11:0]     bcd;
    logic [2:0]      dp;
    logic            lz;
    logic [2:0][7:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic [11:0] bcd_in = '0;
  logic [2:0]  dp_in = '0;
  logic        load_req = 1'b0;
  logic        lz_en = 1'b0;
  logic        load_ack, frame_done;
  logic [7:0]  seg;
  logic [2:0]  wei;

  int n_vec = 0;
  int n_err = 0;
  int k = 0;
  int ack_cnt = 0;
  logic mon_en = 1'b0;
  logic [2:0][7:0] cur = {3{8'hC0}};
  vec_t sb[$];
  vec_t vecs[7];
  vec_t hold[3];

  seg_scan_ctrl #(.NUM_DIG(3), .SLOT_CYC(8), .BLANK_CYC(2)) dut (
    .clk(clk), .res(res), .bcd_in(bcd_in), .dp_in(dp_in), .load_req(load_req),
    .lz_en(lz_en), .load_ack(load_ack), .frame_done(frame_done), .seg(seg), .wei(wei)
  );

  always #5 clk = ~clk;

  // scan-position model: after the k-th edge since release the outputs show slot position k-1
  always @(posedge clk) begin
    #2;
    if (!mon_en) begin
      k = 0;
      cur = {3{8'hC0}};
      lz_en = 1'b0;
      sb.delete();
    end else begin
      int c, d;
      logic [2:0] ew;
      logic [7:0] es;
      logic ed;
      k++;
      c  = (k - 1) % 8;
      d  = ((k - 1) / 8) % 3;
      ew = c < 2 ? 3'b000 : 3'b001 << d;
      es = c < 2 ? 8'hFF : cur[d];
      ed = k % 24 == 0;
      n_vec++;
      if ({wei, seg} !== {ew, es}) begin
        n_err++;
        $display("FAIL scan k=%0d: wei=%b seg=%h, want wei=%b seg=%h", k, wei, seg, ew, es);
      end
      n_vec++;
      if (frame_done !== ed) begin
        n_err++;
        $display("FAIL frame_done k=%0d: got %b, want %b", k, frame_done, ed);
      end
      if (load_ack) begin
        n_vec++;
        if (!frame_done || sb.size() == 0) begin
          n_err++;
          $display("FAIL ack k=%0d: ack=1 with frame_done=%b pending=%0d, want done=1 pending>0",
                   k, frame_done, sb.size());
        end
        if (sb.size() > 0) begin
          vec_t r;
          r = sb.pop_front();
          cur = r.exp;
          lz_en = r.lz;
        end
        ack_cnt++;
      end
    end
  end

  task automatic wait_ack(input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (load_ack) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL %s: load_ack=0 after 40 cycles, want 1", name);
  endtask

  task automatic load_frame(input vec_t v);
    repeat (5) @(negedge clk);
    sb.push_back(v);
    bcd_in = v.bcd;
    dp_in = v.dp;
    load_req = 1'b1;
    wait_ack("load");
    load_req = 1'b0;
    repeat (26) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string name);
    n_vec++;
    if ({seg, wei, load_ack, frame_done} !== {8'hFF, 3'b000, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL %s: seg=%h wei=%b ack=%b done=%b, want seg=ff wei=000 ack=0 done=0",
               name, seg, wei, load_ack, frame_done);
    end
  endtask

  initial begin
    int a0;
    vecs[0] = '{12'h123, 3'b010, 1'b0, {8'hF9, 8'h24, 8'hB0}};
    vecs[1] = '{12'h007, 3'b000, 1'b1, {8'hFF, 8'hFF, 8'hF8}};
    vecs[2] = '{12'h007, 3'b000, 1'b0, {8'hC0, 8'hC0, 8'hF8}};
    vecs[3] = '{12'h0A5, 3'b000, 1'b0, {8'hC0, 8'hBF, 8'h92}};
    vecs[4] = '{12'h000, 3'b111, 1'b1, {8'h7F, 8'h7F, 8'h40}};
    vecs[5] = '{12'h908, 3'b100, 1'b1, {8'h10, 8'hC0, 8'h80}};
    vecs[6] = '{12'hF0E, 3'b000, 1'b1, {8'hBF, 8'hC0, 8'hBF}};
    hold[0] = '{12'h456, 3'b001, 1'b0, {8'h99, 8'h92, 8'h02}};
    hold[1] = '{12'h789, 3'b000, 1'b0, {8'hF8, 8'h80, 8'h90}};
    hold[2] = '{12'h321, 3'b100, 1'b0, {8'h30, 8'hA4, 8'hF9}};

    // reset held high with a request pending: nothing may move
    load_req = 1'b1;
    bcd_in = 12'h999;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check_reset_vals("reset_hold");
    end
    res = 1'b0;
    load_req = 1'b0;
    mon_en = 1'b1;
    repeat (48) @(negedge clk);

    foreach (vecs[i]) load_frame(vecs[i]);

    // reset during a tens drive with a load pending
    load_req = 1'b1;
    bcd_in = 12'h999;
    dp_in = 3'b111;
    for (int i = 0; i < 40 && wei !== 3'b010; i++) @(negedge clk);
    n_vec++;
    if (wei !== 3'b010) begin
      n_err++;
      $display("FAIL find_tens: wei=%b, want 010", wei);
    end
    res = 1'b1;
    mon_en = 1'b0;
    @(negedge clk);
    check_reset_vals("reset_mid");
    res = 1'b0;
    load_req = 1'b0;
    mon_en = 1'b1;
    repeat (30) @(negedge clk);

    // request held across three boundaries, data changing after each ack
    a0 = ack_cnt;
    foreach (hold[i]) sb.push_back(hold[i]);
    load_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bcd_in = hold[i].bcd;
      dp_in = hold[i].dp;
      wait_ack("hold");
    end
    load_req = 1'b0;
    repeat (50) @(negedge clk);
    n_vec++;
    if (ack_cnt - a0 != 3 || sb.size() != 0) begin
      n_err++;
      $display("FAIL hold_acks: acks=%0d pending=%0d, want acks=3 pending=0", ack_cnt - a0, sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
